// File: rtl/alu_stage.sv
// alu_stage: execute/write-back stage feeding the register file write port.
// Define ALU_STAGE_MUL_EN to build the 16-cycle shift-add multiplier.
module alu_stage #(
    parameter int DW = 16,
    parameter int AW = 4
) (
    input  logic          clock,
    input  logic          clear_n,
    input  logic          start,
    input  logic [2:0]    op,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic [AW-1:0] dest,
    output logic          busy,
    output logic [DW-1:0] C,
    output logic [AW-1:0] Caddr,
    output logic          load,
    output logic          carry,
    output logic          zero
);

    localparam int CW = $clog2(DW) + 1;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;
    localparam logic [2:0] OP_SLL = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic {
        IDLE,
        EXEC
    } state_t;

    state_t        state_q;
    logic [DW-1:0] acc_q;
    logic [CW-1:0] cnt_q;
    logic [AW-1:0] dest_q;

    logic [DW:0]   sum_d;
    logic [DW:0]   dif_d;
    logic [DW-1:0] res_d;
    logic          cry_d;
    logic [3:0]    sh_n;
    logic          multi_d;
    logic [DW-1:0] step_d;

`ifdef ALU_STAGE_MUL_EN
    logic          is_mul_q;
    logic [DW-1:0] mcand_q;
    logic [DW-1:0] mplier_q;
`endif

    assign sh_n = b[3:0];

    // Single-cycle result, also the SLL-by-zero and disabled-MUL cases
    always_comb begin
        sum_d = {1'b0, a} + {1'b0, b};
        dif_d = {1'b0, a} - {1'b0, b};
        res_d = '0;
        cry_d = 1'b0;
        unique case (op)
            OP_ADD: begin
                res_d = sum_d[DW-1:0];
                cry_d = sum_d[DW];
            end
            OP_SUB: begin
                res_d = dif_d[DW-1:0];
                cry_d = dif_d[DW];
            end
            OP_AND: res_d = a & b;
            OP_OR:  res_d = a | b;
            OP_XOR: res_d = a ^ b;
            OP_SLT: res_d = {{(DW-1){1'b0}}, $signed(a) < $signed(b)};
            OP_SLL: res_d = a;
            OP_MUL: res_d = '0;
            default: res_d = '0;
        endcase
    end

    always_comb begin
        multi_d = (op == OP_SLL) && (sh_n != 4'd0);
`ifdef ALU_STAGE_MUL_EN
        multi_d = multi_d || (op == OP_MUL);
        step_d  = is_mul_q
                ? acc_q + (mplier_q[0] ? mcand_q : '0)
                : acc_q << 1;
`else
        step_d  = acc_q << 1;
`endif
    end

    always_ff @(posedge clock) begin
        if (!clear_n) begin
            state_q  <= IDLE;
            busy     <= 1'b0;
            load     <= 1'b0;
            C        <= '0;
            Caddr    <= '0;
            carry    <= 1'b0;
            zero     <= 1'b1;
            acc_q    <= '0;
            cnt_q    <= '0;
            dest_q   <= '0;
`ifdef ALU_STAGE_MUL_EN
            is_mul_q <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
`endif
        end else begin
            load <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        dest_q <= dest;
                        if (multi_d) begin
                            state_q <= EXEC;
                            busy    <= 1'b1;
`ifdef ALU_STAGE_MUL_EN
                            is_mul_q <= (op == OP_MUL);
                            mcand_q  <= a;
                            mplier_q <= b;
                            if (op == OP_MUL) begin
                                acc_q <= '0;
                                cnt_q <= CW'(DW);
                            end else begin
                                acc_q <= a;
                                cnt_q <= CW'(sh_n);
                            end
`else
                            acc_q <= a;
                            cnt_q <= CW'(sh_n);
`endif
                        end else begin
                            C     <= res_d;
                            Caddr <= dest;
                            load  <= 1'b1;
                            carry <= cry_d;
                            zero  <= (res_d == '0);
                        end
                    end
                end
                EXEC: begin
                    acc_q <= step_d;
                    cnt_q <= cnt_q - CW'(1);
`ifdef ALU_STAGE_MUL_EN
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
`endif
                    if (cnt_q == CW'(1)) begin
                        state_q <= IDLE;
                        busy    <= 1'b0;
                        load    <= 1'b1;
                        C       <= step_d;
                        Caddr   <= dest_q;
                        carry   <= 1'b0;
                        zero    <= (step_d == '0);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_stage.sv
// tb_alu_stage: random + directed scoreboard bench for alu_stage.
// Honours ALU_STAGE_MUL_EN in the same way as the design.
module tb_alu_stage;

    localparam int DW = 16;
    localparam int AW = 4;
`ifdef ALU_STAGE_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          clear_n = 1'b0;
    logic          start = 1'b0;
    logic [2:0]    op = '0;
    logic [DW-1:0] a = '0;
    logic [DW-1:0] b = '0;
    logic [AW-1:0] dest = '0;
    logic          busy;
    logic [DW-1:0] C;
    logic [AW-1:0] Caddr;
    logic          load;
    logic          carry;
    logic          zero;

    alu_stage #(.DW(DW), .AW(AW)) dut (
        .clock   (clock),
        .clear_n (clear_n),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .dest    (dest),
        .busy    (busy),
        .C       (C),
        .Caddr   (Caddr),
        .load    (load),
        .carry   (carry),
        .zero    (zero)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int          edge_n;
        logic [15:0] c;
        logic [3:0]  ad;
        logic        cy;
        logic        z;
    } exp_t;

    exp_t q[$];
    exp_t last;
    int   done_edge = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at edge %0d",
                     nm, act, exp_v, cyc);
        end
    endtask

    // Reference: result from plain arithmetic, latency in edges past issue
    function automatic exp_t model(input logic [2:0] o,
                                   input logic [15:0] x,
                                   input logic [15:0] y,
                                   input logic [3:0] d,
                                   output int ex);
        exp_t        e;
        logic [16:0] s;
        logic [31:0] p;
        e.edge_n = 0;
        e.ad     = d;
        e.cy     = 1'b0;
        e.c      = '0;
        ex       = 0;
        case (o)
            3'd0: begin
                s    = {1'b0, x} + {1'b0, y};
                e.c  = s[15:0];
                e.cy = s[16];
            end
            3'd1: begin
                e.c  = x - y;
                e.cy = (x < y);
            end
            3'd2: e.c = x & y;
            3'd3: e.c = x | y;
            3'd4: e.c = x ^ y;
            3'd5: e.c = ($signed(x) < $signed(y)) ? 16'd1 : 16'd0;
            3'd6: begin
                e.c = x << y[3:0];
                ex  = int'(y[3:0]);
            end
            default: begin
                if (MUL_EN) begin
                    p   = 32'(x) * 32'(y);
                    e.c = p[15:0];
                    ex  = 16;
                end
            end
        endcase
        e.z = (e.c == 16'd0);
        return e;
    endfunction

    // Monitor: runs shortly after every rising edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #2;
            chk("busy", 32'(busy), 32'(cyc < done_edge));
            chk("load_known", 32'($isunknown(load)), 32'd0);
            if (load === 1'b1) begin
                if (q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_load: got C=%h Caddr=%h expected no load at edge %0d",
                             C, Caddr, cyc);
                end else begin
                    e = q.pop_front();
                    chk("load_edge", 32'(cyc), 32'(e.edge_n));
                    chk("C", 32'(C), 32'(e.c));
                    chk("Caddr", 32'(Caddr), 32'(e.ad));
                    chk("carry", 32'(carry), 32'(e.cy));
                    chk("zero", 32'(zero), 32'(e.z));
                    last = e;
                end
            end else begin
                chk("hold", {10'd0, C, Caddr, carry, zero},
                    {10'd0, last.c, last.ad, last.cy, last.z});
                if (q.size() > 0 && q[0].edge_n <= cyc) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL missing_load: got load=0 expected load at edge %0d",
                             q[0].edge_n);
                    void'(q.pop_front());
                end
            end
        end
    end

    // Issue one op; while the stage is busy, optionally throw ignored starts at it
    task automatic issue(input logic [2:0] o, input logic [15:0] x,
                         input logic [15:0] y, input logic [3:0] d,
                         input bit junk);
        exp_t e;
        int   ex;
        while (cyc < done_edge) begin
            start = junk && ($urandom_range(0, 2) == 0);
            op    = 3'($urandom);
            a     = 16'($urandom);
            b     = 16'($urandom);
            dest  = 4'($urandom);
            @(negedge clock);
        end
        op    = o;
        a     = x;
        b     = y;
        dest  = d;
        start = 1'b1;
        e = model(o, x, y, d, ex);
        e.edge_n  = cyc + 1 + ex;
        done_edge = cyc + 1 + ex;
        q.push_back(e);
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic reset_mid_op();
        if (MUL_EN) issue(3'd7, 16'h0123, 16'h0045, 4'd6, 1'b0);
        else        issue(3'd6, 16'h0001, 16'h000F, 4'd6, 1'b0);
        repeat (7) @(negedge clock);
        clear_n = 1'b0;
        start   = 1'b1;
        op      = 3'd0;
        a       = 16'h1234;
        b       = 16'h1111;
        q.delete();
        done_edge = cyc + 1;
        last = '{edge_n: 0, c: 16'h0, ad: 4'h0, cy: 1'b0, z: 1'b1};
        @(negedge clock);
        clear_n = 1'b1;
        start   = 1'b0;
        repeat (2) @(negedge clock);
        issue(3'd0, 16'h1234, 16'h1111, 4'd9, 1'b0);
    endtask

    initial begin
        logic [2:0]  ro;
        logic [15:0] rb;
        last = '{edge_n: 0, c: 16'h0, ad: 4'h0, cy: 1'b0, z: 1'b1};
        clear_n = 1'b0;
        repeat (2) @(negedge clock);
        clear_n = 1'b1;
        repeat (3) @(negedge clock);

        issue(3'd0, 16'hFFFF, 16'h0001, 4'd3, 1'b0);
        repeat (2) @(negedge clock);
        issue(3'd1, 16'h0002, 16'h0005, 4'd4, 1'b0);
        issue(3'd6, 16'h4BC5, 16'h0004, 4'd1, 1'b0);
        issue(3'd6, 16'h4BC5, 16'h0000, 4'd1, 1'b0);
        issue(3'd7, 16'h0123, 16'h0045, 4'd2, 1'b1);
        issue(3'd2, 16'hF0F0, 16'h0FF0, 4'd5, 1'b0);
        issue(3'd3, 16'h000F, 16'h0F00, 4'd7, 1'b0);
        issue(3'd5, 16'h8000, 16'h0001, 4'd8, 1'b0);
        issue(3'd5, 16'h0001, 16'h8000, 4'd8, 1'b0);
        issue(3'd4, 16'hAAAA, 16'hAAAA, 4'd15, 1'b0);
        reset_mid_op();

        for (int i = 0; i < 400; i++) begin
            ro = 3'($urandom);
            rb = 16'($urandom);
            if ($urandom_range(0, 3) == 0) rb = 16'($urandom_range(0, 3));
            issue(ro, 16'($urandom), rb, 4'($urandom), 1'b1);
            if ($urandom_range(0, 3) == 0)
                repeat ($urandom_range(1, 3)) @(negedge clock);
        end

        repeat (20) @(negedge clock);
        chk("drain", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_stage.md
Name: alu_stage

Overview:
- Sequential execute/write-back stage. Sits directly upstream of the 16x16-bit register file and drives its write port: result data `C`, destination address `Caddr` and the `load` strobe.
- Single-cycle ops: add, sub, and, or, xor, signed set-less-than.
- Multi-cycle ops: an iterative left shift and a 16-cycle shift-add multiply.
- Issue uses a start/busy handshake; completion is a one-cycle `load` pulse.

Parameters:
- DW, 16, data width of operands and result. Must match the register file word width.
- AW, 4, destination register address width (16 registers).

Ports:
- clock  input  1  rising-edge clock.
- clear_n  input  1  synchronous active-low reset.
- start  input  1  issue request; sampled only in IDLE.
- op  input  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT, 110 SLL, 111 MUL.
- a  input  DW  operand A.
- b  input  DW  operand B (SLL uses b[3:0] as the shift count).
- dest  input  AW  destination register address.
- busy  output  1  high while a multi-cycle op is iterating; start is ignored.
- C  output  DW  result, to the register file data input.
- Caddr  output  AW  result address, to the register file write address.
- load  output  1  one-cycle write strobe, to the register file `load`.
- carry  output  1  ADD carry-out / SUB borrow; 0 for all other ops.
- zero  output  1  high when C == 0.

Behaviour:
- Reset and clocking:
  - One clock; reset is synchronous and active-low: on a rising clock edge with clear_n == 0, all state clears.
  - Reset values: state = IDLE, busy = 0, load = 0, C = 0, Caddr = 0, carry = 0, zero = 1.
  - All outputs are registered; no combinational path from any input to any output.
- States: IDLE, EXEC.
- IDLE, start == 1 at edge k: latch a, b, op, dest.
  - ADD, SUB, AND, OR, XOR, SLT, and SLL with b[3:0] == 0: the result is computed and registered at edge k. After edge k: C, Caddr = dest, load = 1, carry and zero are valid. Stay in IDLE.
  - SLL with n = b[3:0] != 0: go to EXEC.
    - Accumulator = a; counter = n.
    - Each edge: shift left 1, zero fill, counter decrements.
    - Result registered with load = 1 at edge k + n.
  - MUL: go to EXEC.
    - 16 shift-add iterations, one per edge, over the latched operands.
    - Result = low DW bits of the unsigned product; upper bits are discarded.
    - Result registered with load = 1 at edge k + 16.
- Handshake:
  - busy = 1 from after edge k until the completing edge. busy = 0 in the same cycle that load = 1.
  - load is high for exactly one cycle per accepted op.
  - C, Caddr, carry and zero hold their values until the next completion.
- Back-to-back: start may be asserted in the cycle load = 1. That op is accepted at the next edge, giving one result per cycle for single-cycle ops.
- start while busy == 1: ignored, not queued. Operands are not re-latched.
- Arithmetic:
  - ADD/SUB wrap modulo 2^DW.
  - carry: ADD carry-out, SUB borrow (a < b unsigned).
  - SLT: C = 1 if signed(a) < signed(b), else 0.
- Reset during EXEC: the op is aborted, no load pulse, state = IDLE. Reset wins over a simultaneous start.
- clear_n held low: start is ignored.

Optional Feature:
- Macro ALU_STAGE_MUL_EN.
- Defined: MUL implemented as above (16-cycle latency).
- Undefined: the multiplier datapath is not compiled. MUL completes as a single-cycle op with C = 0, carry = 0, zero = 1, load = 1, so write-back ordering is preserved.
- All other ops are identical in both builds.

Test Plan:
- Reset: clear_n = 0 for 2 edges, then 1 → load = 0, busy = 0, C = 0x0000, zero = 1; start = 0 keeps load low.
- ADD: a = 0xFFFF, b = 0x0001, dest = 3, start 1 cycle → one cycle after the edge: C = 0x0000, carry = 1, zero = 1, Caddr = 3, load = 1 for exactly 1 cycle. Then SUB a = 0x0002, b = 0x0005 → C = 0xFFFD, carry = 1.
- SLL: a = 0x4BC5, b = 0x0004, dest = 1 → busy high 4 cycles; load after edge k+4 with C = 0xBC50, Caddr = 1. With b = 0x0000: single-cycle, C = 0x4BC5.
- MUL (macro on): a = 0x0123, b = 0x0045, dest = 2 → load after edge k+16 with C = 0x4E6F. A start issued mid-op is ignored (one load pulse only). Macro off: C = 0, load at k+1.
- Back-to-back: AND (0xF0F0, 0x0FF0) then OR (0x000F, 0x0F00) on consecutive cycles → loads on 2 consecutive cycles with C = 0x00F0, then 0x0F0F.
- Reset mid-MUL: clear_n = 0 at iteration 8 → no load pulse ever; busy = 0 next cycle; a new ADD is accepted normally.
